case_code_tracker: RTL

//  Receive-side companion of the free-running counter/case code generator.
//  The generator emits one code per counter value: CODE_A for counter 0..2,

---
 rtl/case_code_tracker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/case_code_tracker.sv
// Consumer-side phase tracker for the counter/case code stream.
// Locks on unambiguous code edges and reconstructs the generator counter.
module case_code_tracker #(
    parameter int          WIDTH  = 8,
    parameter logic [7:0]  CODE_A = 8'd10,
    parameter logic [7:0]  CODE_B = 8'd20,
    parameter logic [7:0]  CODE_C = 8'd30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [7:0]       code_in,
    output logic             locked,
    output logic             cnt_valid,
    output logic [WIDTH-1:0] cnt_out,
    output logic             mismatch,
    output logic [15:0]      err_count
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic [7:0]       prev_code_q;
    logic             prev_vld_q;
    logic [WIDTH-1:0] expect_q;
    logic             locked_q;
    logic             cnt_valid_q;
    logic [WIDTH-1:0] cnt_out_q;
    logic             mismatch_q;
    logic [15:0]      err_count_q;

    logic             is_a;
    logic             is_b;
    logic             is_c;
    logic             legal;
    logic             prev_a;
    logic             prev_b;
    logic             prev_c;
    logic             lock_hit;
    logic [WIDTH-1:0] lock_val;
    logic             pred_a;
    logic             pred_b;
    logic             pred_c;
    logic             pred_ok;
    logic [WIDTH-1:0] expect_d;
    logic [WIDTH-1:0] lock_expect_d;
    logic [15:0]      err_count_d;

    assign is_a  = (code_in == CODE_A);
    assign is_b  = (code_in == CODE_B);
    assign is_c  = (code_in == CODE_C);
    assign legal = is_a | is_b | is_c;

    assign prev_a = prev_vld_q && (prev_code_q == CODE_A);
    assign prev_b = prev_vld_q && (prev_code_q == CODE_B);
    assign prev_c = prev_vld_q && (prev_code_q == CODE_C);

    // Only edges that pin the phase uniquely; A->A and C->C are ambiguous.
    always_comb begin
        lock_hit = 1'b0;
        lock_val = '0;
        unique case (1'b1)
            (is_a && prev_c): begin
                lock_hit = 1'b1;
                lock_val = WIDTH'(0);
            end
            (is_b && prev_a): begin
                lock_hit = 1'b1;
                lock_val = WIDTH'(3);
            end
            (is_c && prev_b): begin
                lock_hit = 1'b1;
                lock_val = WIDTH'(4);
            end
            default: ;
        endcase
    end

    assign pred_a  = (expect_q <= WIDTH'(2));
    assign pred_b  = (expect_q == WIDTH'(3));
    assign pred_c  = !pred_a && !pred_b;
    assign pred_ok = (pred_a && is_a) || (pred_b && is_b) || (pred_c && is_c);

    assign expect_d      = expect_q + WIDTH'(1);
    assign lock_expect_d = lock_val + WIDTH'(1);
    assign err_count_d   = (err_count_q == 16'hFFFF) ? err_count_q
                                                     : err_count_q + 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SEARCH;
            prev_code_q <= '0;
            prev_vld_q  <= 1'b0;
            expect_q    <= '0;
            locked_q    <= 1'b0;
            cnt_valid_q <= 1'b0;
            cnt_out_q   <= '0;
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            cnt_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            if (code_valid) begin
                unique case (state_q)
                    SEARCH: begin
                        prev_code_q <= code_in;
                        prev_vld_q  <= legal;
                        if (lock_hit) begin
                            state_q     <= LOCKED;
                            locked_q    <= 1'b1;
                            cnt_out_q   <= lock_val;
                            cnt_valid_q <= 1'b1;
                            expect_q    <= lock_expect_d;
                        end
                    end
                    LOCKED: begin
                        if (pred_ok) begin
                            cnt_out_q   <= expect_q;
                            cnt_valid_q <= 1'b1;
                            expect_q    <= expect_d;
                        end else begin
                            // The offending sample may itself seed a relock.
                            mismatch_q  <= 1'b1;
                            err_count_q <= err_count_d;
                            state_q     <= SEARCH;
                            locked_q    <= 1'b0;
                            prev_code_q <= code_in;
                            prev_vld_q  <= legal;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign cnt_valid = cnt_valid_q;
    assign cnt_out   = cnt_out_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_count_q;

endmodule
